run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Execution sequencer for the single-cycle MIPS core; produces `cpu_en`, which gates PC update, regfile write and RAM write.
- Provides run / single-step / pause control, one PC breakpoint, syscall-exit halt capture and a retired-instruction counter.
- Sits between the board/debug inputs and the CPU top level.

Parameters:
- PC_W, 32, width of PC and breakpoint address.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- run_req  in  1  one-cycle pulse: enter RUN.
- step_req  in  1  one-cycle pulse: execute exactly one instruction.
- pause_req  in  1  one-cycle pulse: stop in PAUSE.
- clr_req  in  1  one-cycle pulse: leave HALT, clear counter.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- pc_in  in  PC_W  current PC from the core.
- halt_in  in  1  syscall-exit indication (syscall with $v0==10) for the current instruction.
- cpu_en  out  1  combinational; 1 = current instruction retires at next clk edge.
- state  out  3  IDLE=0, RUN=1, STEP=2, PAUSE=3, HALT=4.
- bp_hit  out  1  registered; set when PAUSE is entered via breakpoint.
- halted  out  1  registered; 1 while in HALT.
- retired  out  CNT_W  count of cycles with cpu_en=1.

Behaviour:
- Reset (async, immediate): state=IDLE, bp_hit=0, halted=0, retired=0, bp_skip=0, cpu_en=0. Reset mid-RUN kills the current instruction; no retire.
- Internal `match` = bp_en && (pc_in == bp_addr) && !bp_skip.
- cpu_en:
  - RUN: `!halt_in && !match && !pause_req`.
  - STEP: `!halt_in`.
  - All other states: 0.
- Transitions per clk, first-listed priority wins:
  - IDLE/PAUSE:
    - clr_req: retired=0, bp_hit=0, stay.
    - pause_req: stay.
    - step_req: ->STEP.
    - run_req: ->RUN.
  - RUN:
    - halt_in: ->HALT, halted=1.
    - match: ->PAUSE, bp_hit=1.
    - pause_req: ->PAUSE.
    - Otherwise stay.
    - run_req/step_req ignored.
  - STEP: always one cycle.
    - halt_in: ->HALT.
    - Otherwise ->PAUSE, retiring one instruction.
    - Breakpoint is not checked in STEP.
  - HALT:
    - clr_req: ->IDLE, halted=0, retired=0, bp_hit=0.
    - All other requests ignored.
- bp_skip:
  - Set on any transition PAUSE->RUN or PAUSE->STEP while pc_in==bp_addr.
  - Cleared on the first cycle cpu_en=1. This lets the core resume past the breakpoint instruction.
- bp_hit clears on the next run_req/step_req accepted from PAUSE.
- retired increments by 1 on every clk edge with cpu_en=1; wraps modulo 2^CNT_W without a flag.
- Latency: a request pulse at edge N makes the state visible after N; the first retiring edge is N+1.
- Requests that arrive in an ignoring state are dropped, not queued.
- The halting syscall instruction itself does not retire (cpu_en=0 in that cycle).

Optional Feature:
- Macro: RUN_CTRL_LIMIT_EN.
- Enabled: adds input `limit` (CNT_W) and input `limit_en` (1).
  - In RUN, when limit_en and retired == limit-1 and cpu_en=1, that instruction retires and state ->PAUSE at the same edge. Output `limit_hit` (registered) is set.
  - limit_hit clears like bp_hit.
  - limit=0 with limit_en never triggers.
- Disabled: ports absent; no limit logic; behaviour otherwise identical.

Test Plan:
- Reset then run_req, PC sequence 0x00,0x04,0x08, no bp/halt -> state=1, cpu_en=1 each cycle, retired=3 after 3 edges.
- RUN, bp_en=1, bp_addr=0x0C, pc_in reaches 0x0C -> cpu_en=0 that cycle, state=3, bp_hit=1, retired unchanged. Then run_req -> instruction at 0x0C retires (no re-break); a later pc_in=0x0C breaks again.
- PAUSE, step_req -> exactly one cycle cpu_en=1, retired+1, state returns to 3.
- RUN, halt_in=1 at retired=5 -> cpu_en=0, state=4, halted=1, retired stays 5. run_req ignored; clr_req -> state=0, retired=0.
- pause_req and run_req in the same cycle from PAUSE -> stays PAUSE. Async rst pulse mid-RUN between edges -> outputs zero immediately, state=0.
- (RUN_CTRL_LIMIT_EN) limit=4, limit_en=1, run_req -> exactly 4 retires, state=3, limit_hit=1.

Source files
------------

// File: rtl/run_controller.sv
// Execution sequencer for the single-cycle MIPS core: run/step/pause, one PC breakpoint,
// syscall-exit halt and a retired-instruction counter. Optional macro: RUN_CTRL_LIMIT_EN.
module run_controller #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             pause_req,
    input  logic             clr_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             halt_in,
`ifdef RUN_CTRL_LIMIT_EN
    input  logic [CNT_W-1:0] limit,
    input  logic             limit_en,
    output logic             limit_hit,
`endif
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic             bp_hit,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        PAUSE = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   bp_skip;
    logic   pc_at_bp, match;
    logic   clr_cnt, clr_flags, set_bp_hit, set_skip;

    // Request pulses are single-cycle strobes with no handshake: a pulse is acted on in the
    // cycle it is present if the current state accepts it, otherwise it is dropped.
    assign pc_at_bp = (pc_in == bp_addr);
    assign match    = bp_en && pc_at_bp && !bp_skip;
    assign state    = state_q;

`ifdef RUN_CTRL_LIMIT_EN
    logic [CNT_W-1:0] limit_m1;
    logic             limit_trip, set_limit_hit;
    assign limit_m1   = limit - CNT_W'(1);
    assign limit_trip = limit_en && (limit != '0) && (retired == limit_m1);
`endif

    always_comb begin
        state_d    = state_q;
        cpu_en     = 1'b0;
        clr_cnt    = 1'b0;
        clr_flags  = 1'b0;
        set_bp_hit = 1'b0;
        set_skip   = 1'b0;
`ifdef RUN_CTRL_LIMIT_EN
        set_limit_hit = 1'b0;
`endif
        case (state_q)
            IDLE, PAUSE: begin
                if (clr_req) begin
                    clr_cnt   = 1'b1;
                    clr_flags = 1'b1;
                end else if (pause_req) begin
                    state_d = state_q;
                end else if (step_req || run_req) begin
                    state_d   = step_req ? STEP : RUN;
                    clr_flags = 1'b1;
                    // Resuming from the breakpoint PC must not re-break on the same instruction.
                    set_skip  = (state_q == PAUSE) && pc_at_bp;
                end
            end
            RUN: begin
                cpu_en = !halt_in && !match && !pause_req;
                if (halt_in) begin
                    state_d = HALT;
                end else if (match) begin
                    state_d    = PAUSE;
                    set_bp_hit = 1'b1;
                end else if (pause_req) begin
                    state_d = PAUSE;
`ifdef RUN_CTRL_LIMIT_EN
                end else if (limit_trip) begin
                    state_d       = PAUSE;
                    set_limit_hit = 1'b1;
`endif
                end
            end
            STEP: begin
                cpu_en  = !halt_in;
                state_d = halt_in ? HALT : PAUSE;
            end
            HALT: begin
                if (clr_req) begin
                    state_d   = IDLE;
                    clr_cnt   = 1'b1;
                    clr_flags = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            halted  <= 1'b0;
            retired <= '0;
            bp_hit  <= 1'b0;
            bp_skip <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == HALT);
            if (clr_cnt)
                retired <= '0;
            else if (cpu_en)
                retired <= retired + CNT_W'(1);
            if (set_bp_hit)
                bp_hit <= 1'b1;
            else if (clr_flags)
                bp_hit <= 1'b0;
            if (set_skip)
                bp_skip <= 1'b1;
            else if (cpu_en)
                bp_skip <= 1'b0;
        end
    end

`ifdef RUN_CTRL_LIMIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            limit_hit <= 1'b0;
        else if (set_limit_hit)
            limit_hit <= 1'b1;
        else if (clr_flags)
            limit_hit <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed self-checking bench for run_controller; covers the RUN_CTRL_LIMIT_EN build when defined.
module tb_run_controller;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             run_req, step_req, pause_req, clr_req, bp_en, halt_in;
    logic [PC_W-1:0]  bp_addr, pc_in;
    logic             cpu_en, bp_hit, halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
`ifdef RUN_CTRL_LIMIT_EN
    logic [CNT_W-1:0] limit;
    logic             limit_en, limit_hit;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    run_controller #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .run_req(run_req), .step_req(step_req), .pause_req(pause_req), .clr_req(clr_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc_in(pc_in), .halt_in(halt_in),
`ifdef RUN_CTRL_LIMIT_EN
        .limit(limit), .limit_en(limit_en), .limit_hit(limit_hit),
`endif
        .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .halted(halted), .retired(retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; run_req = 0; step_req = 0; pause_req = 0; clr_req = 0;
        bp_en = 0; bp_addr = '0; pc_in = '0; halt_in = 0;
`ifdef RUN_CTRL_LIMIT_EN
        limit = '0; limit_en = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_retired", retired, 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        check("rst_halted", 32'(halted), 0);
        rst = 1'b0;

        // Plain run over three sequential PCs
        run_req = 1; #1;
        check("idle_cpu_en", 32'(cpu_en), 0);
        tick(); run_req = 0;
        check("run_state", 32'(state), 1);
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(i * 4); #1;
            check("run_cpu_en", 32'(cpu_en), 1);
            tick();
        end
        check("run_retired3", retired, 3);

        // Breakpoint at 0x0C, resume past it, then break again
        bp_en = 1; bp_addr = 32'h0C; pc_in = 32'h0C; #1;
        check("bp_cpu_en", 32'(cpu_en), 0);
        tick();
        check("bp_state", 32'(state), 3);
        check("bp_hit", 32'(bp_hit), 1);
        check("bp_retired", retired, 3);
        run_req = 1; tick(); run_req = 0;
        check("resume_state", 32'(state), 1);
        check("resume_bp_clr", 32'(bp_hit), 0);
        #1;
        check("skip_cpu_en", 32'(cpu_en), 1);
        tick();
        check("skip_retired", retired, 4);
        pc_in = 32'h10; tick();
        pc_in = 32'h0C; #1;
        check("rebreak_cpu_en", 32'(cpu_en), 0);
        tick();
        check("rebreak_state", 32'(state), 3);
        check("rebreak_hit", 32'(bp_hit), 1);
        check("rebreak_retired", retired, 5);

        // Single step from PAUSE
        step_req = 1; tick(); step_req = 0;
        check("step_state", 32'(state), 2);
        check("step_bp_clr", 32'(bp_hit), 0);
        #1;
        check("step_cpu_en", 32'(cpu_en), 1);
        tick();
        check("step_back_pause", 32'(state), 3);
        check("step_retired", retired, 6);

        // pause_req outranks run_req in PAUSE
        pause_req = 1; run_req = 1; tick(); pause_req = 0; run_req = 0;
        check("pause_wins", 32'(state), 3);

        // Syscall-exit halt, ignored run_req, then clear
        pc_in = 32'h20; run_req = 1; tick(); run_req = 0;
        check("run2_state", 32'(state), 1);
        halt_in = 1; #1;
        check("halt_cpu_en", 32'(cpu_en), 0);
        tick(); halt_in = 0;
        check("halt_state", 32'(state), 4);
        check("halt_halted", 32'(halted), 1);
        check("halt_retired", retired, 6);
        run_req = 1; tick(); run_req = 0;
        check("halt_ignore_run", 32'(state), 4);
        clr_req = 1; tick(); clr_req = 0;
        check("clr_state", 32'(state), 0);
        check("clr_retired", retired, 0);
        check("clr_halted", 32'(halted), 0);

        // pause_req in RUN kills that cycle; clr_req in PAUSE zeroes counter
        run_req = 1; tick(); run_req = 0;
        pc_in = 32'h24; tick();
        check("run3_retired", retired, 1);
        pause_req = 1; #1;
        check("pause_cpu_en", 32'(cpu_en), 0);
        tick(); pause_req = 0;
        check("pause_state", 32'(state), 3);
        check("pause_retired", retired, 1);
        clr_req = 1; tick(); clr_req = 0;
        check("pause_clr_ret", retired, 0);
        check("pause_clr_state", 32'(state), 3);

        // Async reset between edges mid-RUN
        run_req = 1; tick(); run_req = 0;
        pc_in = 32'h28; tick();
        check("run4_retired", retired, 1);
        rst = 1; #1;
        check("arst_state", 32'(state), 0);
        check("arst_cpu_en", 32'(cpu_en), 0);
        check("arst_retired", retired, 0);
        rst = 0;

`ifdef RUN_CTRL_LIMIT_EN
        bp_en = 0; limit = 4; limit_en = 1;
        run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(i * 4); #1;
            check("lim_cpu_en", 32'(cpu_en), 1);
            tick();
        end
        check("lim_state", 32'(state), 3);
        check("lim_hit", 32'(limit_hit), 1);
        check("lim_retired", retired, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
